quiz_score_keeper: RTL and testbench

Score-keeping and buzzer-arbitration controller for the four-contestant quiz board. It debounces four contestant buzzer keys and three host keys, and latches the first contestant to buzz while locking out the others. It applies host add/subtract judgements to that contestant's score. Its outputs are the four 4-bit scores plus active-low contestant selects, which feed the seven-segment score display stage directly.

---
 rtl/quiz_pkg.sv | 40 ++++
 rtl/quiz_score_keeper_debounce.sv | 45 ++++
 rtl/quiz_score_keeper.sv | 127 ++++++++++++
 tb/tb_quiz_score_keeper.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/quiz_pkg.sv
// Shared types and defaults for the quiz board score keeper.
// State and winner encodings plus the display select decode.
package quiz_pkg;

  localparam int DEB_CYCLES_DEF = 240000;
  localparam int MAX_SCORE_DEF  = 9;
  localparam int INIT_SCORE_DEF = 0;

  localparam int NKEYS = 7;
  localparam int K_ADD = 4;
  localparam int K_SUB = 5;
  localparam int K_CLR = 6;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  typedef enum logic [2:0] {
    W_NONE = 3'd0,
    W_P1   = 3'd1,
    W_P2   = 3'd2,
    W_P3   = 3'd3,
    W_P4   = 3'd4
  } winner_t;

  function automatic logic [3:0] sel_n(winner_t w);
    logic [3:0] s;
    s = 4'b1111;
    case (w)
      W_P1:    s = 4'b1110;
      W_P2:    s = 4'b1101;
      W_P3:    s = 4'b1011;
      W_P4:    s = 4'b0111;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quiz_score_keeper_debounce.sv
// Key conditioner: 2-FF synchronizer, stability counter,
// and a one-cycle pulse on each debounced press.
module key_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] cnt;

  // sync, count stable mismatch, then register the falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      deb   <= 1'b1;
      deb_d <= 1'b1;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= key;
      s2    <= s1;
      deb_d <= deb;
      pulse <= deb_d & ~deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quiz_score_keeper.sv
// Buzzer arbitration and score registers for four contestants.
// First buzz locks the floor; host keys judge or re-arm.
module quiz_score_keeper
  import quiz_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int MAX_SCORE  = MAX_SCORE_DEF,
  parameter int INIT_SCORE = INIT_SCORE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_p1,
  input  logic       key_p2,
  input  logic       key_p3,
  input  logic       key_p4,
  input  logic       key_add,
  input  logic       key_sub,
  input  logic       key_clr,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic [3:0] score4,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       c4,
  output logic [3:0] win_n
);

  logic [NKEYS-1:0] raw;
  logic [NKEYS-1:0] pulse;

  assign raw = {key_clr, key_sub, key_add,
                key_p4, key_p3, key_p2, key_p1};

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .key  (raw[i]),
      .pulse(pulse[i])
    );
  end

  state_t     state;
  state_t     state_d;
  winner_t    winner;
  winner_t    win_d;
  logic [3:0] score   [4];
  logic [3:0] score_d [4];
  logic [3:0] win_q;

  // arbitration and judgement; clr overrides everything
  always_comb begin
    state_d = state;
    win_d   = winner;
    score_d = score;
    if (pulse[K_CLR]) begin
      state_d = IDLE;
      win_d   = W_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (pulse[0]) begin
            win_d   = W_P1;
            state_d = LOCKED;
          end else if (pulse[1]) begin
            win_d   = W_P2;
            state_d = LOCKED;
          end else if (pulse[2]) begin
            win_d   = W_P3;
            state_d = LOCKED;
          end else if (pulse[3]) begin
            win_d   = W_P4;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (pulse[K_ADD] ^ pulse[K_SUB]) begin
            state_d = IDLE;
            for (int i = 0; i < 4; i++) begin
              if (winner == 3'(i + 1)) begin
                if (pulse[K_ADD]) begin
                  score_d[i] = (score[i] >= 4'(MAX_SCORE))
                             ? 4'(MAX_SCORE)
                             : score[i] + 4'd1;
                end else begin
                  score_d[i] = (score[i] == 4'd0)
                             ? 4'd0
                             : score[i] - 4'd1;
                end
              end
            end
          end
        end
      endcase
    end
  end

  // state, winner, scores and decoded selects
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      winner <= W_NONE;
      score  <= '{default: 4'(INIT_SCORE)};
      win_q  <= 4'b1111;
    end else begin
      state  <= state_d;
      winner <= win_d;
      score  <= score_d;
      win_q  <= sel_n(win_d);
    end
  end

  assign score1 = score[0];
  assign score2 = score[1];
  assign score3 = score[2];
  assign score4 = score[3];
  assign win_n  = win_q;
  assign c1     = win_q[0];
  assign c2     = win_q[1];
  assign c3     = win_q[2];
  assign c4     = win_q[3];

endmodule

// File: tb/tb_quiz_score_keeper.sv
// Directed bench for quiz_score_keeper with DEB_CYCLES=4.
// Hand-computed scores, selects and latencies.
module tb_quiz_score_keeper;

  localparam logic [6:0] ADD = 7'b0010000;
  localparam logic [6:0] SUB = 7'b0100000;
  localparam logic [6:0] CLR = 7'b1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] keys = '1;
  logic [3:0] score1, score2, score3, score4;
  logic       c1, c2, c3, c4;
  logic [3:0] win_n;
  logic [3:0] c;

  int n_cmp = 0;
  int n_bad = 0;
  int p1_pulses = 0;

  assign c = {c4, c3, c2, c1};

  quiz_score_keeper #(
    .DEB_CYCLES(4),
    .MAX_SCORE (9),
    .INIT_SCORE(0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_p1 (keys[0]),
    .key_p2 (keys[1]),
    .key_p3 (keys[2]),
    .key_p4 (keys[3]),
    .key_add(keys[4]),
    .key_sub(keys[5]),
    .key_clr(keys[6]),
    .score1 (score1),
    .score2 (score2),
    .score3 (score3),
    .score4 (score4),
    .c1     (c1),
    .c2     (c2),
    .c3     (c3),
    .c4     (c4),
    .win_n  (win_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.pulse[0]) p1_pulses++;
  end

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(logic [6:0] m, int n);
    keys = keys & ~m;
    tick(n);
    keys = keys | m;
  endtask

  task automatic press(logic [6:0] m);
    hold(m, 6);
    tick(10);
  endtask

  task automatic judge(int k, logic [6:0] j);
    press(7'(1 << k));
    press(j);
  endtask

  initial begin
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rst_s1", 32'(score1), 0);
    check("rst_s2", 32'(score2), 0);
    check("rst_s3", 32'(score3), 0);
    check("rst_s4", 32'(score4), 0);
    check("rst_c", 32'(c), 32'hF);
    check("rst_win", 32'(win_n), 32'hF);

    keys[2] = 1'b0;
    tick(7);
    check("lat_early_c3", 32'(c3), 1);
    tick(1);
    check("lat_c3", 32'(c3), 0);
    check("lat_win", 32'(win_n), 32'hB);
    keys[2] = 1'b1;
    tick(10);

    press(CLR);
    check("clr_win", 32'(win_n), 32'hF);

    hold(7'b0001010, 6);
    tick(10);
    check("tie_c", 32'(c), 32'hD);
    press(7'b0001000);
    check("lock_p4", 32'(win_n), 32'hD);

    press(CLR);
    for (int i = 0; i < 3; i++) judge(0, ADD);
    check("s1_three", 32'(score1), 3);
    check("s1_keep_c", 32'(c), 32'hE);

    for (int i = 0; i < 9; i++) judge(2, ADD);
    check("s3_nine", 32'(score3), 9);
    judge(2, ADD);
    check("s3_sat", 32'(score3), 9);

    judge(3, SUB);
    check("s4_floor", 32'(score4), 0);

    press(CLR);
    p1_pulses = 0;
    hold(7'b0000001, 3);
    tick(1);
    hold(7'b0000001, 6);
    tick(10);
    check("bounce_cnt", p1_pulses, 1);
    check("bounce_c", 32'(c), 32'hE);

    press(CLR);
    hold(7'b0000010, 3);
    tick(10);
    check("short_win", 32'(win_n), 32'hF);

    for (int i = 0; i < 5; i++) judge(1, ADD);
    check("s2_five", 32'(score2), 5);
    press(7'b0000010);
    check("s2_lock", 32'(c), 32'hD);
    press(CLR | ADD);
    check("clr_add_s2", 32'(score2), 5);
    check("clr_add_c", 32'(c), 32'hF);
    press(7'b0000100);
    check("idle_rebuzz", 32'(win_n), 32'hB);

    press(ADD | SUB);
    check("addsub_s3", 32'(score3), 9);
    check("addsub_win", 32'(win_n), 32'hB);
    press(7'b0000001);
    check("still_lock", 32'(win_n), 32'hB);
    press(SUB);
    check("sub_after", 32'(score3), 8);

    for (int i = 0; i < 7; i++) judge(3, ADD);
    check("s4_seven", 32'(score4), 7);
    press(7'b0001000);
    check("s4_lock", 32'(win_n), 32'h7);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_s1", 32'(score1), 0);
    check("arst_s2", 32'(score2), 0);
    check("arst_s3", 32'(score3), 0);
    check("arst_s4", 32'(score4), 0);
    check("arst_c", 32'(c), 32'hF);
    check("arst_win", 32'(win_n), 32'hF);
    rst = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
